// File: rtl/seg7_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// seg7_pkg : active-low 7-segment pattern constants and capture states
// Revision : 1.0
// ------------------------------------------------------------------
package seg7_pkg;

   // Segment order a..g maps to bit6..bit0, low = lit.
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// seg7_encoder : active-low segment pattern -> {hit, blank, nibble}
// Revision     : 1.0
// ------------------------------------------------------------------
module seg7_encoder
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       hit,
   output logic       blank,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'd0;
      blank  = (seg == SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// seg_scan_capture : settle-and-capture readback of a scanned 7-seg bus
// Revision         : 1.0
// ------------------------------------------------------------------
module seg_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic [6:0]              seg_in,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_done,
   output logic                    err_pulse
);

   localparam int              CW      = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

   logic [NUM_DIGITS-1:0] s_an;
   logic [6:0]            s_seg;
   logic [CW-1:0]         cnt;
   logic [NUM_DIGITS-1:0] mask;
   state_t                state;

   logic [NUM_DIGITS-1:0] sel;
   logic [NUM_DIGITS-1:0] sel_m1;
   logic                  an_ok;
   logic                  change;
   logic                  cnt_max;
   logic                  do_cap;
   logic                  mask_full;
   logic                  enc_hit;
   logic                  enc_blank;
   logic [3:0]            enc_nibble;
   logic                  bad_pattern;

   // The incoming bus is compared against the held sample, so a change is
   // seen on the same edge that loads it.
   assign sel         = ~s_an;
   assign sel_m1      = sel - ONE;
   assign an_ok       = (sel != '0) && ((sel & sel_m1) == '0);
   assign change      = (an_in != s_an) || (seg_in != s_seg);
   assign cnt_max     = (cnt == CNT_MAX);
   assign do_cap      = (state == ST_SETTLE) && an_ok && cnt_max;
   assign mask_full   = &mask;
   assign bad_pattern = !enc_hit && !enc_blank;

   seg7_encoder u_enc (
      .seg    (s_seg),
      .hit    (enc_hit),
      .blank  (enc_blank),
      .nibble (enc_nibble)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_an  <= '1;
         s_seg <= SEG_BLANK;
      end else begin
         s_an  <= an_in;
         s_seg <= seg_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mask        <= '0;
         digits_out  <= '0;
         digit_valid <= '0;
         digit_err   <= '0;
         frame_done  <= 1'b0;
         err_pulse   <= 1'b0;
      end else if (clr) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mask        <= '0;
         digits_out  <= '0;
         digit_valid <= '0;
         digit_err   <= '0;
         frame_done  <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         frame_done <= mask_full;
         err_pulse  <= 1'b0;

         if (change || !an_ok) begin
            cnt <= '0;
         end else if (!cnt_max) begin
            cnt <= cnt + CW'(1);
         end

         case (state)
            ST_IDLE: begin
               if (an_ok) state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!an_ok)       state <= ST_IDLE;
               else if (cnt_max) state <= change ? ST_SETTLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (!an_ok)       state <= ST_IDLE;
               else if (change)  state <= ST_SETTLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (do_cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i]) begin
                  digits_out[4*i +: 4] <= enc_hit ? enc_nibble : 4'd0;
                  digit_valid[i]       <= enc_hit;
                  digit_err[i]         <= bad_pattern;
               end
            end
            err_pulse <= bad_pattern;
         end

         mask <= (mask_full ? '0 : mask) | ({NUM_DIGITS{do_cap}} & sel);
      end
   end

endmodule

`default_nettype wire

// File: doc/seg_scan_capture.md
# seg_scan_capture

Capture block for multiplexed 7-segment display buses: samples a scanned anode/segment bus, waits for each digit's pattern to settle, and encodes the active-low segment pattern back to a 4-bit hex value per digit. It pairs with the `decoder_7_seg` encoding used by the clock practice designs. Its purpose is display loop-back self-check and on-board readback of what the multiplexer actually drives.

## Interface
- `NUM_DIGITS`, 4, number of scanned digits / anode lines.
- `STABLE_CYCLES`, 8, consecutive identical samples required before a capture; must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `an_in`  in  NUM_DIGITS  anode selects, active-low; bit i low selects digit i.
- `seg_in`  in  7  segments, active-low; bit6 = a … bit0 = g.
- `clr`  in  1  synchronous clear of all captured state.
- `digits_out`  out  4*NUM_DIGITS  digit i value at bits [4i+3:4i].
- `digit_valid`  out  NUM_DIGITS  digit i holds a decoded hex pattern.
- `digit_err`  out  NUM_DIGITS  digit i last captured an unrecognised pattern.
- `frame_done`  out  1  one-cycle pulse when every digit has been captured since the last frame.
- `err_pulse`  out  1  one-cycle pulse on any error capture.

## Operation
- Input stage: `an_in` and `seg_in` are registered every cycle into `s_an` and `s_seg`.
- Anode validity: exactly one bit of `s_an` is low. All-high and multi-low patterns are invalid.
- Stability counter `cnt`:
  - resets to 0 whenever the current sample differs from the previous sample, or the anode is invalid;
  - otherwise increments and saturates at STABLE_CYCLES-1.
- State machine:
  - IDLE → SETTLE on a valid anode.
  - SETTLE → CAPTURE when `cnt` == STABLE_CYCLES-1.
  - SETTLE → IDLE on an invalid anode.
  - CAPTURE → SETTLE (cnt=0) on any sample change with a valid anode; CAPTURE → IDLE on an invalid anode.
  - Exactly one capture per anode dwell.
- Capture, for digit i selected by `s_an`:
  - Pattern matches the table: nibble written, valid[i]=1, err[i]=0.
  - 7'b1111111 (blank): nibble 0, valid[i]=0, err[i]=0.
  - Any other pattern: nibble 0, valid[i]=0, err[i]=1, `err_pulse` asserted.
  - Every capture sets mask[i].
- Frame: when mask becomes all-ones, `frame_done` pulses on the next cycle and mask clears to 0.
- `clr`: clears digits_out, digit_valid, digit_err, mask and cnt, and forces IDLE. It wins over a same-cycle capture or frame completion; no pulses are issued in that cycle.

## Timing
- Reset values: digits_out=0, digit_valid=0, digit_err=0, frame_done=0, err_pulse=0, state IDLE, cnt=0, mask=0.
- Capture latency: with inputs constant before edge 0, `s_*` loads at edge 0, `cnt` reaches STABLE_CYCLES-1 at edge STABLE_CYCLES-1, and outputs update at edge STABLE_CYCLES.
- `err_pulse` is high in the same cycle the erroneous capture appears on the outputs.
- `frame_done` is high one cycle after the last mask bit is set.
- Glitch: any change before a capture restarts the full STABLE_CYCLES window.
- Reset mid-dwell: the dwell is discarded; after `rst` deasserts, a full window is required again.
- `cnt` width: $clog2(STABLE_CYCLES)+1.

## Structure
- Shared package `seg7_pkg` holds the 16 active-low pattern constants, shared with the decoder, in a..g order:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - SEG_BLANK = 1111111
- The package also holds the state enumeration.
- One sub-module, `seg7_encoder`: combinational 7-bit pattern → {hit, blank, nibble}.

## Test plan
- an_in=1110, seg_in=0010010 held 8 cycles → digits_out[3:0]=2, digit_valid=0001 at edge 8; no further capture while held.
- Same stimulus, but seg_in changes to 0000110 after 5 cycles → no capture of 2; 3 is captured 8 edges after the change.
- an_in=1101, seg_in=1111110 held 8 cycles → digit_err=0010, digits_out[7:4]=0, one-cycle err_pulse.
- Scan digits 0..3 with 1, 2, 3, 4, each for 10 cycles → digits_out=16'h4321, digit_valid=1111, exactly one frame_done.
- an_in=1100 or 1111 held for 20 cycles → no capture, outputs unchanged.
- Assert `rst` at cycle 5 of a dwell, then `clr` coincident with a capture → all outputs 0, no frame_done and no err_pulse.
